// File: rtl/cache_set_associative.sv
// cache_set_associative
// Read-only N-way set-associative instruction cache between a CICERO
// execution block and shared instruction memory. Hits answer in the same
// cycle. A miss issues one memory request, waits for the response for as
// long as it takes, then fills the victim way and answers with the returned
// word. Replacement uses the lowest invalid way if there is one, otherwise
// a per-set round-robin pointer. A flush invalidates every line.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   addr_in_valid   requester address valid
//   addr_in         requester address, held until addr_in_ready
//   addr_in_ready   request answered this cycle, data_out valid
//   data_out        read data (0 when not answering)
//   addr_out_valid  memory request valid (registered)
//   addr_out        memory request address (registered)
//   addr_out_ready  memory accepts the request
//   data_in_valid   memory response valid
//   data_in         memory response data
//   flush           invalidate all lines
//   hit_count       number of accepted hits
//   miss_count      number of misses issued
module cache_set_associative #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int SET_BITS   = 4,
  parameter int WAYS       = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  addr_in_valid,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  addr_in_ready,
  output logic [DWIDTH-1:0]     data_out,
  output logic                  addr_out_valid,
  output logic [ADDR_WIDTH-1:0] addr_out,
  input  logic                  addr_out_ready,
  input  logic                  data_in_valid,
  input  logic [DWIDTH-1:0]     data_in,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int TAG_WIDTH = ADDR_WIDTH - SET_BITS;
  localparam int SETS      = 1 << SET_BITS;
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]                                 state_q, state_d;
  logic [SETS-1:0][WAYS-1:0]                  valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0][TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [SETS-1:0][WAYS-1:0][DWIDTH-1:0]      data_q, data_d;
  logic [SETS-1:0][WAY_BITS-1:0]              ptr_q, ptr_d;
  logic                                       flush_pending_q, flush_pending_d;
  logic [CNT_WIDTH-1:0]                       hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0]                       miss_count_q, miss_count_d;
  logic [ADDR_WIDTH-1:0]                      addr_q, addr_d;

  logic [SET_BITS-1:0]  in_set, fill_set;
  logic [TAG_WIDTH-1:0] in_tag, fill_tag;
  logic                 hit, inv_found;
  logic [WAY_BITS-1:0]  hit_way, victim_way;

  assign in_set   = addr_in[SET_BITS-1:0];
  assign in_tag   = addr_in[ADDR_WIDTH-1:SET_BITS];
  assign fill_set = addr_q[SET_BITS-1:0];
  assign fill_tag = addr_q[ADDR_WIDTH-1:SET_BITS];

  assign addr_out_valid = (state_q == S_REQ);
  assign addr_out       = addr_q;
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;

  // Tag lookup on the requester address; at most one way can match.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[in_set][w] && (tag_q[in_set][w] == in_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  // Victim for the pending fill: lowest invalid way first, round-robin
  // pointer only when the set is full.
  always_comb begin
    inv_found  = 1'b0;
    victim_way = ptr_q[fill_set];
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[fill_set][w]) begin
        inv_found  = 1'b1;
        victim_way = WAY_BITS'(w);
      end
    end
  end

  // Main controller: lookup, miss request, fill, flush.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    tag_d           = tag_q;
    data_d          = data_q;
    ptr_d           = ptr_q;
    flush_pending_d = flush_pending_q;
    hit_count_d     = hit_count_q;
    miss_count_d    = miss_count_q;
    addr_d          = addr_q;
    addr_in_ready   = 1'b0;
    data_out        = '0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_FLUSH;
        end else if (addr_in_valid) begin
          if (hit) begin
            addr_in_ready = 1'b1;
            data_out      = data_q[in_set][hit_way];
            hit_count_d   = hit_count_q + CNT_WIDTH'(1);
          end else begin
            addr_d       = addr_in;
            miss_count_d = miss_count_q + CNT_WIDTH'(1);
            state_d      = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) flush_pending_d = 1'b1;
        if (addr_out_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) flush_pending_d = 1'b1;
        if (data_in_valid) begin
          valid_d[fill_set][victim_way] = 1'b1;
          tag_d[fill_set][victim_way]   = fill_tag;
          data_d[fill_set][victim_way]  = data_in;
          // The pointer advances only when it actually chose the victim.
          if (!inv_found) begin
            if (ptr_q[fill_set] == WAY_BITS'(WAYS - 1)) ptr_d[fill_set] = '0;
            else ptr_d[fill_set] = ptr_q[fill_set] + WAY_BITS'(1);
          end
          addr_in_ready = 1'b1;
          data_out      = data_in;
          state_d       = (flush_pending_q || flush) ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        valid_d         = '0;
        ptr_d           = '0;
        flush_pending_d = 1'b0;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and bookkeeping, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      valid_q         <= '0;
      ptr_q           <= '0;
      flush_pending_q <= 1'b0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
      addr_q          <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      ptr_q           <= ptr_d;
      flush_pending_q <= flush_pending_d;
      hit_count_q     <= hit_count_d;
      miss_count_q    <= miss_count_d;
      addr_q          <= addr_d;
    end
  end

  // Tag and data storage need no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_cache_set_associative.sv
// tb_cache_set_associative
// Directed bench for cache_set_associative with default parameters
// (16-bit data/address, 16 sets, 2 ways, 32-bit counters).
module tb_cache_set_associative;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_in_valid;
  logic [15:0] addr_in;
  logic        addr_in_ready;
  logic [15:0] data_out;
  logic        addr_out_valid;
  logic [15:0] addr_out;
  logic        addr_out_ready;
  logic        data_in_valid;
  logic [15:0] data_in;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int total = 0;
  int bad   = 0;
  int exp_hits   = 0;
  int exp_misses = 0;

  cache_set_associative dut (
    .clk           (clk),
    .rst           (rst),
    .addr_in_valid (addr_in_valid),
    .addr_in       (addr_in),
    .addr_in_ready (addr_in_ready),
    .data_out      (data_out),
    .addr_out_valid(addr_out_valid),
    .addr_out      (addr_out),
    .addr_out_ready(addr_out_ready),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .flush         (flush),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 unit later, well before the next edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, "_hits"}, hit_count, 32'(exp_hits));
    checkOutput({tag, "_misses"}, miss_count, 32'(exp_misses));
  endtask

  // Full miss transaction: rdly cycles of memory backpressure, then mdly
  // waiting cycles before the memory returns d.
  task automatic readMiss(input logic [15:0] a, input logic [15:0] d, input int rdly, input int mdly);
    addr_in_valid = 1'b1;
    addr_in       = a;
    #1;
    checkOutput("miss_ready", 32'(addr_in_ready), 32'd0);
    checkOutput("miss_dout", 32'(data_out), 32'd0);
    exp_misses++;
    nextCycle();
    for (int i = 0; i < rdly; i++) begin
      addr_out_ready = 1'b0;
      #1;
      checkOutput("bp_valid", 32'(addr_out_valid), 32'd1);
      checkOutput("bp_addr", 32'(addr_out), 32'(a));
      checkOutput("bp_ready", 32'(addr_in_ready), 32'd0);
      nextCycle();
    end
    addr_out_ready = 1'b1;
    #1;
    checkOutput("req_valid", 32'(addr_out_valid), 32'd1);
    checkOutput("req_addr", 32'(addr_out), 32'(a));
    checkOutput("req_ready", 32'(addr_in_ready), 32'd0);
    nextCycle();
    addr_out_ready = 1'b0;
    for (int i = 0; i < mdly; i++) begin
      #1;
      checkOutput("wait_valid", 32'(addr_out_valid), 32'd0);
      checkOutput("wait_ready", 32'(addr_in_ready), 32'd0);
      nextCycle();
    end
    data_in_valid = 1'b1;
    data_in       = d;
    #1;
    checkOutput("fill_ready", 32'(addr_in_ready), 32'd1);
    checkOutput("fill_dout", 32'(data_out), 32'(d));
    nextCycle();
    data_in_valid = 1'b0;
    data_in       = 16'h0;
    addr_in_valid = 1'b0;
  endtask

  task automatic readHit(input logic [15:0] a, input logic [15:0] d);
    addr_in_valid = 1'b1;
    addr_in       = a;
    #1;
    checkOutput("hit_ready", 32'(addr_in_ready), 32'd1);
    checkOutput("hit_dout", 32'(data_out), 32'(d));
    exp_hits++;
    nextCycle();
    addr_in_valid = 1'b0;
  endtask

  task automatic applyStimulus();
    // Reset state.
    rst = 1'b1; addr_in_valid = 1'b0; addr_in = 16'h0; addr_out_ready = 1'b0;
    data_in_valid = 1'b0; data_in = 16'h0; flush = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rst_ready", 32'(addr_in_ready), 32'd0);
    checkOutput("rst_aov", 32'(addr_out_valid), 32'd0);
    checkOutput("rst_addr_out", 32'(addr_out), 32'd0);
    checkOutput("rst_dout", 32'(data_out), 32'd0);
    checkCounts("rst");
    rst = 1'b0;
    nextCycle();

    // First miss then same-cycle hit.
    readMiss(16'h0013, 16'hBEEF, 0, 1);
    readHit(16'h0013, 16'hBEEF);
    checkCounts("first");

    // Conflict sequence in set 3.
    readMiss(16'h0023, 16'h2323, 0, 1);
    readMiss(16'h0033, 16'h3333, 0, 1);
    readHit(16'h0023, 16'h2323);
    readHit(16'h0033, 16'h3333);
    readMiss(16'h0013, 16'h1313, 0, 1);
    readHit(16'h0033, 16'h3333);
    readMiss(16'h0023, 16'h2424, 0, 1);
    readHit(16'h0013, 16'h1313);
    checkCounts("conflict");

    // Backpressure and long memory latency.
    readMiss(16'h0105, 16'h0105, 5, 7);
    readHit(16'h0105, 16'h0105);
    checkCounts("backpressure");

    // Flush during S_WAIT: the fill answers, then the cache is flushed.
    addr_in_valid = 1'b1; addr_in = 16'h0044;
    #1;
    checkOutput("fw_miss_ready", 32'(addr_in_ready), 32'd0);
    exp_misses++;
    nextCycle();
    addr_out_ready = 1'b1;
    #1;
    checkOutput("fw_req_valid", 32'(addr_out_valid), 32'd1);
    nextCycle();
    addr_out_ready = 1'b0; flush = 1'b1;
    #1;
    checkOutput("fw_wait_ready", 32'(addr_in_ready), 32'd0);
    nextCycle();
    flush = 1'b0; data_in_valid = 1'b1; data_in = 16'h4444;
    #1;
    checkOutput("fw_fill_ready", 32'(addr_in_ready), 32'd1);
    checkOutput("fw_fill_dout", 32'(data_out), 32'h4444);
    nextCycle();
    data_in_valid = 1'b0; data_in = 16'h0;
    #1;
    checkOutput("fw_flush_ready", 32'(addr_in_ready), 32'd0);
    checkOutput("fw_flush_dout", 32'(data_out), 32'd0);
    nextCycle();
    addr_in_valid = 1'b0;
    readMiss(16'h0044, 16'h4545, 0, 1);
    readMiss(16'h0105, 16'h5151, 0, 0);
    checkCounts("flush_wait");

    // Flush and a would-be hit in the same idle cycle.
    addr_in_valid = 1'b1; addr_in = 16'h0044; flush = 1'b1;
    #1;
    checkOutput("fh_ready", 32'(addr_in_ready), 32'd0);
    checkOutput("fh_dout", 32'(data_out), 32'd0);
    nextCycle();
    flush = 1'b0; addr_in_valid = 1'b0;
    #1;
    checkCounts("flush_hit");
    nextCycle();
    readMiss(16'h0044, 16'h4646, 0, 1);
    checkCounts("flush_hit_after");

    // Reset in S_WAIT followed by a stray memory response.
    addr_in_valid = 1'b1; addr_in = 16'h0055;
    #1;
    nextCycle();
    addr_out_ready = 1'b1;
    nextCycle();
    addr_out_ready = 1'b0; rst = 1'b1; addr_in_valid = 1'b0;
    nextCycle();
    rst = 1'b0; data_in_valid = 1'b1; data_in = 16'hDEAD;
    exp_hits = 0; exp_misses = 0;
    #1;
    checkOutput("rw_ready", 32'(addr_in_ready), 32'd0);
    checkOutput("rw_dout", 32'(data_out), 32'd0);
    checkOutput("rw_aov", 32'(addr_out_valid), 32'd0);
    checkOutput("rw_addr_out", 32'(addr_out), 32'd0);
    checkCounts("rw");
    nextCycle();
    data_in_valid = 1'b0; data_in = 16'h0;
    nextCycle();
    readMiss(16'h0055, 16'h5555, 0, 1);
    readHit(16'h0055, 16'h5555);
    checkCounts("rw_after");
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
